wb_write_arbiter: RTL



---
 rtl/wb_write_arbiter_pkg.sv | 19 +
 rtl/wb_write_arbiter_if.sv | 45 ++++
 rtl/wb_pend_queue.sv | 74 +++++++
 rtl/wb_write_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg: register-file widths, arbiter defaults and a saturating helper.
// WB_ARB_DEPTH / WB_ARB_STARVE_LIMIT may be predefined to override the defaults.
`ifndef WB_ARB_DEPTH
`define WB_ARB_DEPTH 2
`endif
`ifndef WB_ARB_STARVE_LIMIT
`define WB_ARB_STARVE_LIMIT 4
`endif
package wb_write_arbiter_pkg;
   localparam int LEN_REG_ADDRESS = 4;
   localparam int LEN_REGISTER = 32;
   localparam int WB_ARB_DEPTH = `WB_ARB_DEPTH;
   localparam int WB_ARB_STARVE_LIMIT = `WB_ARB_STARVE_LIMIT;
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction
endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: pipeline WB, multicycle handshake, hazard and register-file write signals.
// WB_ARB_STATS_EN adds squash_cnt / max_occ.
interface wb_write_arbiter_if
   import wb_write_arbiter_pkg::*;
#(
   parameter int ADDR_W = LEN_REG_ADDRESS,
   parameter int DATA_W = LEN_REGISTER
`ifdef WB_ARB_STATS_EN
   , parameter int DEPTH = WB_ARB_DEPTH
`endif
);
   logic p_wb_en;
   logic [ADDR_W-1:0] p_wb_addr;
   logic [DATA_W-1:0] p_wb_data;
   logic m_valid;
   logic m_ready;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic [ADDR_W-1:0] src1;
   logic [ADDR_W-1:0] src2;
   logic use_src2;
   logic pend_hazard;
   logic stall_req;
   logic wb_en;
   logic [ADDR_W-1:0] wb_address;
   logic [DATA_W-1:0] wb_data;
`ifdef WB_ARB_STATS_EN
   logic [15:0] squash_cnt;
   logic [$clog2(DEPTH):0] max_occ;
`endif
   modport slave (
      input p_wb_en, p_wb_addr, p_wb_data, m_valid, m_addr, m_data, src1, src2, use_src2,
      output m_ready, pend_hazard, stall_req, wb_en, wb_address, wb_data
`ifdef WB_ARB_STATS_EN
      , output squash_cnt, max_occ
`endif
   );
   modport master (
      output p_wb_en, p_wb_addr, p_wb_data, m_valid, m_addr, m_data, src1, src2, use_src2,
      input m_ready, pend_hazard, stall_req, wb_en, wb_address, wb_data
`ifdef WB_ARB_STATS_EN
      , input squash_cnt, max_occ
`endif
   );
endinterface

// File: rtl/wb_pend_queue.sv
// wb_pend_queue: circular {valid, addr, data} queue with per-entry squash and hazard compare.
// WB_ARB_STATS_EN exposes the per-cycle squash count.
module wb_pend_queue
   import wb_write_arbiter_pkg::*;
#(
   parameter int ADDR_W = LEN_REG_ADDRESS,
   parameter int DATA_W = LEN_REGISTER,
   parameter int DEPTH = WB_ARB_DEPTH
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic push_valid,
   input logic [ADDR_W-1:0] push_addr,
   input logic [DATA_W-1:0] push_data,
   input logic pop,
   input logic squash_en,
   input logic [ADDR_W-1:0] squash_addr,
   input logic [ADDR_W-1:0] src1,
   input logic [ADDR_W-1:0] src2,
   input logic use_src2,
   output logic head_valid,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [$clog2(DEPTH):0] count,
`ifdef WB_ARB_STATS_EN
   output logic [$clog2(DEPTH):0] squash_n,
`endif
   output logic hit
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [DEPTH-1:0] v, sq_mask, hit_mask;
   logic [ADDR_W-1:0] a [DEPTH];
   logic [DATA_W-1:0] d [DEPTH];
   logic [PW-1:0] head, tail;
   always_comb begin
      sq_mask = '0;
      hit_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sq_mask[i] = squash_en && v[i] && a[i] == squash_addr;
         hit_mask[i] = v[i] && (a[i] == src1 || (use_src2 && a[i] == src2));
      end
   end
   assign hit = |hit_mask;
   assign head_valid = v[head];
   assign head_addr = a[head];
   assign head_data = d[head];
`ifdef WB_ARB_STATS_EN
   assign squash_n = CW'($countones(sq_mask));
`endif
   // a push always lands on a slot other than the popped head, so push wins per entry
   always_ff @(posedge clk) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         v <= '0;
      end else begin
         head <= head + PW'(pop);
         tail <= tail + PW'(push);
         count <= count + CW'(push) - CW'(pop);
         for (int i = 0; i < DEPTH; i++)
            v[i] <= (push && tail == PW'(i)) ? push_valid :
                    (sq_mask[i] || (pop && head == PW'(i))) ? 1'b0 : v[i];
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         a[tail] <= push_addr;
         d[tail] <= push_data;
      end
   end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the WB stage and a multicycle unit.
// WB_ARB_STATS_EN adds squash_cnt and max_occ statistics.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int ADDR_W = LEN_REG_ADDRESS,
   parameter int DATA_W = LEN_REGISTER,
   parameter int DEPTH = WB_ARB_DEPTH,
   parameter int STARVE_LIMIT = WB_ARB_STARVE_LIMIT
) (
   input logic clk,
   input logic rst,
   wb_write_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] count;
   logic empty, pop, bypass, push, push_valid, head_valid, q_hit, m_hit, stall_req;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [SW-1:0] starve, starve_nxt;
`ifdef WB_ARB_STATS_EN
   logic [CW-1:0] squash_n, max_occ;
   logic [15:0] squash_cnt;
`endif
   assign empty = count == '0;
   assign pop = rst && !bus.p_wb_en && !empty;
   assign bypass = !bus.p_wb_en && empty && bus.m_valid;
   assign bus.m_ready = rst && count < CW'(DEPTH);
   assign push = bus.m_valid && bus.m_ready && !bypass;
   // the multicycle result is older than a same-cycle pipeline write to the same register
   assign push_valid = !(bus.p_wb_en && bus.m_addr == bus.p_wb_addr);
   assign bus.wb_en = rst && (bus.p_wb_en || (empty ? bus.m_valid : head_valid));
   assign bus.wb_address = bus.p_wb_en ? bus.p_wb_addr : !empty ? head_addr : bus.m_addr;
   assign bus.wb_data = bus.p_wb_en ? bus.p_wb_data : !empty ? head_data : bus.m_data;
   assign m_hit = bus.m_valid && !bus.m_ready &&
                  (bus.m_addr == bus.src1 || (bus.use_src2 && bus.m_addr == bus.src2));
   assign bus.pend_hazard = rst && (q_hit || m_hit);
   assign bus.stall_req = stall_req;
   wb_pend_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_queue (
      .clk(clk),
      .rst(rst),
      .push(push),
      .push_valid(push_valid),
      .push_addr(bus.m_addr),
      .push_data(bus.m_data),
      .pop(pop),
      .squash_en(bus.p_wb_en),
      .squash_addr(bus.p_wb_addr),
      .src1(bus.src1),
      .src2(bus.src2),
      .use_src2(bus.use_src2),
      .head_valid(head_valid),
      .head_addr(head_addr),
      .head_data(head_data),
      .count(count),
`ifdef WB_ARB_STATS_EN
      .squash_n(squash_n),
`endif
      .hit(q_hit)
   );
   assign starve_nxt = (empty || pop) ? '0 :
                       (starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1);
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve <= '0;
         stall_req <= 1'b0;
      end else begin
         starve <= starve_nxt;
         stall_req <= empty ? 1'b0 : (starve_nxt == SW'(STARVE_LIMIT)) ? 1'b1 : stall_req;
      end
   end
`ifdef WB_ARB_STATS_EN
   assign bus.squash_cnt = squash_cnt;
   assign bus.max_occ = max_occ;
   always_ff @(posedge clk) begin
      if (!rst) begin
         squash_cnt <= '0;
         max_occ <= '0;
      end else begin
         squash_cnt <= sat_add16(squash_cnt, 16'(squash_n) + 16'(push && !push_valid));
         max_occ <= (count > max_occ) ? count : max_occ;
      end
   end
`endif
endmodule
